// File: rtl/cdb_arbiter_if.sv
// Result-source handshakes and the common-data-bus broadcast for cdb_arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ROB_W  = 2
);
    logic              add_valid;
    logic [TAG_W-1:0]  add_tag;
    logic [DATA_W-1:0] add_data;
    logic [ROB_W-1:0]  add_rob;
    logic              add_ready;

    logic              mul_valid;
    logic [TAG_W-1:0]  mul_tag;
    logic [DATA_W-1:0] mul_data;
    logic [ROB_W-1:0]  mul_rob;
    logic              mul_ready;

    logic              ld_valid;
    logic [TAG_W-1:0]  ld_tag;
    logic [DATA_W-1:0] ld_data;
    logic [ROB_W-1:0]  ld_rob;
    logic              ld_ready;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_id;
    logic [DATA_W-1:0] cdb_data;
    logic [ROB_W-1:0]  cdb_rob;
    logic              protocol_err;

    modport master (
        output add_valid, add_tag, add_data, add_rob,
        output mul_valid, mul_tag, mul_data, mul_rob,
        output ld_valid, ld_tag, ld_data, ld_rob,
        input  add_ready, mul_ready, ld_ready,
        input  cdb_valid, cdb_id, cdb_data, cdb_rob, protocol_err
    );

    modport slave (
        input  add_valid, add_tag, add_data, add_rob,
        input  mul_valid, mul_tag, mul_data, mul_rob,
        input  ld_valid, ld_tag, ld_data, ld_rob,
        output add_ready, mul_ready, ld_ready,
        output cdb_valid, cdb_id, cdb_data, cdb_rob, protocol_err
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry buffer per result source, round-robin pick,
// registered broadcast of tag/data/rob to the snooping consumers.
module cdb_arbiter #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ROB_W  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int unsigned NSRC     = 3;
    localparam logic [1:0]  LAST_RST = 2'd2;

    logic              in_valid [NSRC];
    logic [TAG_W-1:0]  in_tag   [NSRC];
    logic [DATA_W-1:0] in_data  [NSRC];
    logic [ROB_W-1:0]  in_rob   [NSRC];

    logic [NSRC-1:0]   full_q;
    logic [TAG_W-1:0]  tag_q    [NSRC];
    logic [DATA_W-1:0] data_q   [NSRC];
    logic [ROB_W-1:0]  rob_q    [NSRC];
    logic [1:0]        last_q;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_id_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [ROB_W-1:0]  cdb_rob_q;
    logic              protocol_err_q;

    logic [NSRC-1:0]   grant_c;
    logic [1:0]        gnt_idx_c;
    logic [1:0]        cand_c;
    logic              any_grant_c;
    logic [NSRC-1:0]   ready_c;
    logic [NSRC-1:0]   accept_c;
    logic [NSRC-1:0]   capture_c;
    logic              bad_tag_c;

    always_comb begin
        in_valid[0] = bus.add_valid; in_tag[0] = bus.add_tag; in_data[0] = bus.add_data; in_rob[0] = bus.add_rob;
        in_valid[1] = bus.mul_valid; in_tag[1] = bus.mul_tag; in_data[1] = bus.mul_data; in_rob[1] = bus.mul_rob;
        in_valid[2] = bus.ld_valid;  in_tag[2] = bus.ld_tag;  in_data[2] = bus.ld_data;  in_rob[2] = bus.ld_rob;
    end

    // Round-robin: scan from the source after the last winner, first full buffer wins.
    always_comb begin
        grant_c     = '0;
        gnt_idx_c   = last_q;
        cand_c      = '0;
        any_grant_c = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            cand_c = 2'((32'(last_q) + 32'(k) + 32'd1) % NSRC);
            if (!any_grant_c && full_q[cand_c]) begin
                grant_c[cand_c] = 1'b1;
                gnt_idx_c       = cand_c;
                any_grant_c     = 1'b1;
            end
        end
    end

    // A buffer being drained this cycle may refill at the same edge; tag 0 is swallowed.
    always_comb begin
        ready_c   = '0;
        accept_c  = '0;
        capture_c = '0;
        bad_tag_c = 1'b0;
        for (int x = 0; x < NSRC; x++) begin
            ready_c[x]   = !flush && (!full_q[x] || grant_c[x]);
            accept_c[x]  = in_valid[x] && ready_c[x];
            capture_c[x] = accept_c[x] && (in_tag[x] != '0);
            bad_tag_c    = bad_tag_c | (accept_c[x] && (in_tag[x] == '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q         <= '0;
            last_q         <= LAST_RST;
            cdb_valid_q    <= 1'b0;
            cdb_id_q       <= '0;
            cdb_data_q     <= '0;
            cdb_rob_q      <= '0;
            protocol_err_q <= 1'b0;
            for (int x = 0; x < NSRC; x++) begin
                tag_q[x]  <= '0;
                data_q[x] <= '0;
                rob_q[x]  <= '0;
            end
        end else if (flush) begin
            full_q      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_id_q    <= '0;
            cdb_data_q  <= '0;
            cdb_rob_q   <= '0;
        end else begin
            for (int x = 0; x < NSRC; x++) begin
                if (capture_c[x]) begin
                    full_q[x] <= 1'b1;
                    tag_q[x]  <= in_tag[x];
                    data_q[x] <= in_data[x];
                    rob_q[x]  <= in_rob[x];
                end else if (grant_c[x]) begin
                    full_q[x] <= 1'b0;
                end
            end
            if (any_grant_c) begin
                cdb_valid_q <= 1'b1;
                cdb_id_q    <= tag_q[gnt_idx_c];
                cdb_data_q  <= data_q[gnt_idx_c];
                cdb_rob_q   <= rob_q[gnt_idx_c];
                last_q      <= gnt_idx_c;
            end else begin
                cdb_valid_q <= 1'b0;
                cdb_id_q    <= '0;
                cdb_data_q  <= '0;
                cdb_rob_q   <= '0;
            end
            protocol_err_q <= protocol_err_q | bad_tag_c;
        end
    end

    assign bus.add_ready    = ready_c[0];
    assign bus.mul_ready    = ready_c[1];
    assign bus.ld_ready     = ready_c[2];
    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_id       = cdb_id_q;
    assign bus.cdb_data     = cdb_data_q;
    assign bus.cdb_rob      = cdb_rob_q;
    assign bus.protocol_err = protocol_err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed results, expected broadcasts queued in order.
module tb_cdb_arbiter;
    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] data;
        logic [1:0]  rob;
    } item_t;

    logic clk;
    logic rst_n;
    logic flush;

    cdb_arbiter_if #(.TAG_W(4), .DATA_W(64), .ROB_W(2)) bus ();

    cdb_arbiter #(.TAG_W(4), .DATA_W(64), .ROB_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    item_t q_add[$];
    item_t q_mul[$];
    item_t q_ld[$];
    item_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int add_stalls = 0;
    logic [2:0] rdy_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input int tag, input longint data, input int rob);
        item_t it;
        it.tag  = 4'(tag);
        it.data = 64'(data);
        it.rob  = 2'(rob);
        return it;
    endfunction

    // Scoreboard monitor: every broadcast must match the next expected result, idle must be zero.
    always @(negedge clk) begin
        item_t e;
        if (bus.cdb_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cdb_unexpected: got tag %0d expected no broadcast at %0t", bus.cdb_id, $time);
            end else begin
                e = exp_q.pop_front();
                chk("cdb_id",   80'(bus.cdb_id),   80'(e.tag));
                chk("cdb_data", 80'(bus.cdb_data), 80'(e.data));
                chk("cdb_rob",  80'(bus.cdb_rob),  80'(e.rob));
            end
        end else begin
            chk("cdb_idle_zero", 80'({bus.cdb_id, bus.cdb_data, bus.cdb_rob}), 80'(0));
        end
    end

    task automatic drive_heads();
        if (q_add.size() > 0) begin
            bus.add_valid = 1'b1; bus.add_tag = q_add[0].tag; bus.add_data = q_add[0].data; bus.add_rob = q_add[0].rob;
        end else begin
            bus.add_valid = 1'b0; bus.add_tag = '0; bus.add_data = '0; bus.add_rob = '0;
        end
        if (q_mul.size() > 0) begin
            bus.mul_valid = 1'b1; bus.mul_tag = q_mul[0].tag; bus.mul_data = q_mul[0].data; bus.mul_rob = q_mul[0].rob;
        end else begin
            bus.mul_valid = 1'b0; bus.mul_tag = '0; bus.mul_data = '0; bus.mul_rob = '0;
        end
        if (q_ld.size() > 0) begin
            bus.ld_valid = 1'b1; bus.ld_tag = q_ld[0].tag; bus.ld_data = q_ld[0].data; bus.ld_rob = q_ld[0].rob;
        end else begin
            bus.ld_valid = 1'b0; bus.ld_tag = '0; bus.ld_data = '0; bus.ld_rob = '0;
        end
    endtask

    // One clock: present queue heads, sample ready before the edge, retire accepted items.
    task automatic run_cycle(input logic fl);
        logic a0, a1, a2;
        @(negedge clk);
        flush = fl;
        drive_heads();
        #1;
        rdy_seen = {bus.ld_ready, bus.mul_ready, bus.add_ready};
        a0 = bus.add_valid && bus.add_ready;
        a1 = bus.mul_valid && bus.mul_ready;
        a2 = bus.ld_valid && bus.ld_ready;
        if (bus.add_valid && !bus.add_ready) add_stalls++;
        @(posedge clk);
        if (a0) void'(q_add.pop_front());
        if (a1) void'(q_mul.pop_front());
        if (a2) void'(q_ld.pop_front());
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0);
    endtask

    task automatic check_drained(input string name);
        chk({name, "_exp_left"}, 80'(exp_q.size()), 80'(0));
        chk({name, "_src_left"}, 80'(q_add.size() + q_mul.size() + q_ld.size()), 80'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive_heads();
        #12;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_readies", 80'({bus.ld_ready, bus.mul_ready, bus.add_ready}), 80'(3'b111));
        chk("reset_perr",    80'(bus.protocol_err), 80'(0));
        chk("reset_valid",   80'(bus.cdb_valid), 80'(0));

        // Single adder result
        q_add.push_back(mk(1, 'h10, 2));
        exp_q.push_back(mk(1, 'h10, 2));
        run_n(4);
        check_drained("single");

        // Two simultaneous batches, each broadcast add, mul, ld
        do_reset();
        for (int b = 0; b < 2; b++) begin
            q_add.push_back(mk(1, 'h100 + b, 0));
            q_mul.push_back(mk(4, 'h400 + b, 1));
            q_ld.push_back(mk(6, 'h600 + b, 3));
            exp_q.push_back(mk(1, 'h100 + b, 0));
            exp_q.push_back(mk(4, 'h400 + b, 1));
            exp_q.push_back(mk(6, 'h600 + b, 3));
            run_n(5);
        end
        check_drained("batch");

        // Adder streams 1,2,3 while mul holds 5: fair interleave 1,5,2,3
        add_stalls = 0;
        q_add.push_back(mk(1, 'hA1, 1));
        q_add.push_back(mk(2, 'hA2, 2));
        q_add.push_back(mk(3, 'hA3, 3));
        q_mul.push_back(mk(5, 'hB5, 0));
        exp_q.push_back(mk(1, 'hA1, 1));
        exp_q.push_back(mk(5, 'hB5, 0));
        exp_q.push_back(mk(2, 'hA2, 2));
        exp_q.push_back(mk(3, 'hA3, 3));
        run_n(7);
        chk("add_stall_cycles", 80'(add_stalls), 80'(1));
        check_drained("stream");

        // Fill all buffers, then flush: nothing may be broadcast
        q_add.push_back(mk(2, 'hC2, 1));
        q_mul.push_back(mk(5, 'hC5, 2));
        q_ld.push_back(mk(7, 'hC7, 3));
        run_cycle(1'b0);
        @(negedge clk);
        flush = 1'b1;
        drive_heads();
        #1;
        chk("flush_readies_low", 80'({bus.ld_ready, bus.mul_ready, bus.add_ready}), 80'(3'b000));
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post_flush_valid",   80'(bus.cdb_valid), 80'(0));
        chk("post_flush_readies", 80'({bus.ld_ready, bus.mul_ready, bus.add_ready}), 80'(3'b111));
        run_n(4);
        check_drained("flush");

        // Tag 0 from mul: accepted, dropped, sticky protocol_err
        q_mul.push_back(mk(0, 'h55, 1));
        run_cycle(1'b0);
        chk("mul_ready_tag0", 80'(rdy_seen[1]), 80'(1));
        run_n(3);
        chk("perr_set", 80'(bus.protocol_err), 80'(1));
        q_add.push_back(mk(2, 'h77, 3));
        exp_q.push_back(mk(2, 'h77, 3));
        run_n(4);
        chk("perr_sticky", 80'(bus.protocol_err), 80'(1));
        check_drained("tag0");

        // Asynchronous reset while a broadcast is on the bus
        q_add.push_back(mk(3, 'hABCD, 1));
        exp_q.push_back(mk(3, 'hABCD, 1));
        run_cycle(1'b0);
        run_cycle(1'b0);
        @(negedge clk);
        chk("pre_reset_valid", 80'(bus.cdb_valid), 80'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid",   80'(bus.cdb_valid), 80'(0));
        chk("async_payload", 80'({bus.cdb_id, bus.cdb_data, bus.cdb_rob}), 80'(0));
        chk("async_perr",    80'(bus.protocol_err), 80'(0));
        chk("async_readies", 80'({bus.ld_ready, bus.mul_ready, bus.add_ready}), 80'(3'b111));
        #3;
        rst_n = 1'b1;
        run_n(2);
        check_drained("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus (CDB) arbiter and broadcaster for the Tomasulo core. It accepts completed results from the adder, multiplier and load units and holds each in a one-entry buffer. It picks one buffered result per cycle by round-robin and drives the registered `cdb_id`/`cdb_data` broadcast that the reservation stations, register-status table and ROB snoop. It is the writer side of the CDB that the reservation stations read.

## Interface
- `TAG_W`, default 4: tag width; tag 0 is `notag`.
- `DATA_W`, default 64: result width.
- `ROB_W`, default 2: ROB slot index width.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous squash of all buffered and broadcasting results (branch mispredict).
- `add_valid`, `mul_valid`, `ld_valid`  in  1 each  source has a result.
- `add_tag`, `mul_tag`, `ld_tag`  in  TAG_W each  producing RS tag (add_1..3, mult_1..2, ld_1..3).
- `add_data`, `mul_data`, `ld_data`  in  DATA_W each  result value.
- `add_rob`, `mul_rob`, `ld_rob`  in  ROB_W each  destination ROB slot.
- `add_ready`, `mul_ready`, `ld_ready`  out  1 each  arbiter can accept a result this cycle.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_id`  out  TAG_W  broadcast tag; 0 when idle.
- `cdb_data`  out  DATA_W  broadcast value; 0 when idle.
- `cdb_rob`  out  ROB_W  broadcast ROB slot; 0 when idle.
- `protocol_err`  out  1  sticky: a source presented `valid` with tag 0.

## Operation
- Source index order: 0 = add, 1 = mul, 2 = ld. Each source has a buffer {full, tag, data, rob}.
- Handshake: a transfer occurs at a posedge when `x_valid && x_ready`. The buffer captures tag/data/rob and sets full. Sources hold valid and payload stable until the transfer.
- `x_ready = !flush && (!full[x] || grant[x])`. A buffer being drained this cycle can refill at the same edge.
- Grant is combinational from the current full bits. Round-robin starts at `(last+1) mod 3` and takes the first full buffer. At most one grant per cycle.
- On grant: at the next posedge, the CDB registers load the buffer's tag/data/rob and `cdb_valid` goes to 1. The buffer clears unless it refills at the same edge. `last` takes the granted index.
- No grant: at the next posedge `cdb_valid` goes to 0 and `cdb_id`, `cdb_data`, `cdb_rob` go to 0. `last` is unchanged.
- Tag 0 with valid: the transfer is accepted and the payload is discarded (not buffered). `protocol_err` is set and stays 1 until reset.
- `flush` is high at a posedge:
  - all full bits clear;
  - CDB outputs go to idle values;
  - no capture and no grant take effect;
  - `last` is unchanged;
  - `protocol_err` is unchanged.
- Reset (asynchronous, any time including mid-broadcast):
  - full bits = 0;
  - `last` = 2, so the adder has first priority;
  - `cdb_valid` = 0, `cdb_id` = 0, `cdb_data` = 0, `cdb_rob` = 0;
  - `protocol_err` = 0;
  - all `x_ready` = 1 once `rst_n` is high and `flush` is low.

## Timing
- Latency: a result captured at edge E0 is on the CDB at edge E1 at the earliest, i.e. one cycle after the handshake.
- A lone source streaming valid every cycle is broadcast every cycle, with `ready` held high by refill-on-drain.
- CDB outputs are registered and stable for one full cycle; consumers sample them at the following edge.
- With all three buffers full, each source is granted once every 3 cycles. Worst-case wait from capture to broadcast is 3 cycles.
- A stalled source sees `x_ready` = 0 while its buffer is full and not granted. No result is dropped or duplicated.

## Test plan
- Reset, then drive add_valid with tag 1, data 0x10, rob 2 for one cycle -> next cycle `cdb_valid` = 1, `cdb_id` = 1, `cdb_data` = 0x10, `cdb_rob` = 2; the following cycle `cdb_id` = 0 and `cdb_data` = 0.
- Drive all three sources valid on the same cycle (tags 1, 4, 6) -> CDB shows 1, 4, 6 on consecutive cycles. A second simultaneous batch then broadcasts 1, 4, 6 again (rotation continues from last = 2).
- Adder streams tags 1, 2, 3 back-to-back while mul holds tag 5 -> the CDB sequence alternates fairly (1, 5, 2, 3). `add_ready` drops while the adder's buffer is full and not granted, and no tag is lost or repeated.
- Fill all buffers, then assert `flush` for one cycle -> `cdb_valid` = 0 next cycle, nothing is broadcast afterward, and all readies = 1.
- Present mul_valid with tag 0 -> `mul_ready` = 1, nothing is broadcast, and `protocol_err` = 1 and stays 1 through later traffic until `rst_n` is pulsed.
- Assert `rst_n` = 0 asynchronously while `cdb_valid` = 1 -> all outputs go to their reset values immediately, without waiting for a clock edge.
